pc_sequencer: RTL
=================

# pc_sequencer

Registered program-counter controller for the KGP-RISC core. It owns the architectural PC and the link register (ra), sequences each instruction through fetch and execute with a request/acknowledge handshake to instruction memory, and resolves the branch decision (BranchOp plus ALU flags) into the next PC. It sits between instruction memory, the decoder and the ALU. It replaces the combinational next-PC path with a clocked, stall-tolerant one.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, sequential increment in bytes
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- imem_req  out  1  fetch request, held high until acknowledged
- imem_addr  out  32  fetch address; equals pc
- imem_ack  in  1  instruction-memory acknowledge, one-cycle pulse
- instr_valid  out  1  one-cycle pulse: fetched word is valid for decode
- ex_done  in  1  execute stage finished; branch_op, label and flags are valid this cycle
- branch_op  in  4  branch opcode from decoder
- label  in  32  branch target address
- carry, zero, sign  in  1 each  ALU flags for the current instruction
- halt  in  1  level; stops sequencing at the next instruction boundary
- pc  out  32  current PC register
- ra  out  32  link register
- taken  out  1  one-cycle pulse when the resolved next PC differs from pc+PC_STEP
- misalign  out  1  sticky flag: a branch target had nonzero bits [1:0]
- busy  out  1  high in any state except HALTED

## Operation
- States: BOOT, FETCH, EXEC, HALTED.
- BOOT → FETCH unconditionally on the first clock after reset deasserts.
- FETCH drives imem_req=1 and imem_addr=pc. On imem_ack it moves to EXEC and pulses instr_valid in that same cycle.
- EXEC waits for ex_done. When ex_done=1 it updates pc, ra, taken and misalign, then goes to HALTED if halt=1, otherwise to FETCH.
- HALTED goes to FETCH when halt=0. pc is preserved.
- Next-PC selection, with seq = pc+PC_STEP:
  - 0000 → seq
  - 0001 b → label
  - 0010 bl → label, and ra←seq
  - 0011 bcy → carry ? label : seq
  - 0100 bncy → carry ? seq : label
  - 0101 br → ra
  - 0110 bltz → sign ? label : seq
  - 0111 bz → zero ? label : seq
  - 1000 bnz → zero ? seq : label
  - 1001–1111 → seq (treated as no-op)
- Arithmetic is 32-bit unsigned, modulo 2^32: pc=FFFF_FFFC with seq gives 0000_0000.
- Any selected target (label or ra) has bits [1:0] forced to 0 before loading pc. If the unmasked target had nonzero low bits, misalign is set and stays set until reset.
- bl followed by br returns to the instruction after the bl. br with no earlier bl returns to ra's reset value, 0.

## Timing
- Reset values: pc=RESET_PC, ra=0, state=BOOT, imem_req=0, instr_valid=0, taken=0, misalign=0, busy=1.
- Minimum instruction period is 2 cycles: FETCH with same-cycle ack, then EXEC with same-cycle ex_done.
- pc, ra, taken and misalign update on the clock edge at which EXEC sees ex_done=1. taken is high for exactly the following cycle.
- imem_ack is ignored outside FETCH, and ex_done is ignored outside EXEC.
- halt raised during FETCH or EXEC takes effect only after the current instruction retires. It is not sampled mid-handshake.
- If reset asserts mid-operation, all registers return to their reset values immediately (asynchronously) and any outstanding fetch is abandoned: imem_req drops.
- imem_addr is stable for as long as imem_req=1.

## Structure
- Shared package kgp_pkg holds:
  - BranchOp localparams (BR_SEQ, BR_B, BR_BL, BR_BCY, BR_BNCY, BR_BR, BR_BLTZ, BR_BZ, BR_BNZ)
  - the state enum/encoding
  - the PC width constant (32)
- One combinational sub-module, next_pc_select. Inputs: branch_op, pc, label, ra, flags. Outputs: next-PC value, link-write enable, raw target low bits.
- The FSM and registers live in pc_sequencer.

## Test plan
- Reset release with RESET_PC=0: imem_addr=0 and imem_req=1 one cycle after BOOT. ack+ex_done with op 0000 → pc=4, taken=0.
- At pc=0x10, op bl, label=0x40: pc=0x40, ra=0x14, taken=1 for one cycle. Later op br → pc=0x14.
- At pc=0x20, bz with zero=1 and label=0x80 → pc=0x80. Same with zero=0 → pc=0x24. bcy/bncy/bltz each exercised with flag=0 and flag=1.
- pc=FFFF_FFFC, op 0000 → pc=0. op b with label=0x103 → pc=0x100 and misalign=1, which persists through further instructions.
- imem_ack delayed 3 cycles: imem_req and imem_addr are held steady, and no instr_valid pulse occurs before the ack. halt raised mid-EXEC → state HALTED after ex_done, pc held; halt=0 resumes fetching at the held pc.
- reset pulled low during EXEC: pc=RESET_PC, ra=0 and imem_req=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP-RISC program-counter controller:
// datapath width, reset/step constants, branch opcodes and the
// sequencer state encoding.
package kgp_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [PC_W-1:0] PC_STEP_DEF  = 32'd4;

  // BranchOp encodings from the decoder; 1001-1111 fall through as no-ops
  localparam logic [3:0] BR_SEQ  = 4'b0000;
  localparam logic [3:0] BR_B    = 4'b0001;
  localparam logic [3:0] BR_BL   = 4'b0010;
  localparam logic [3:0] BR_BCY  = 4'b0011;
  localparam logic [3:0] BR_BNCY = 4'b0100;
  localparam logic [3:0] BR_BR   = 4'b0101;
  localparam logic [3:0] BR_BLTZ = 4'b0110;
  localparam logic [3:0] BR_BZ   = 4'b0111;
  localparam logic [3:0] BR_BNZ  = 4'b1000;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake. The sequencer is the master: it
// raises imem_req with a stable imem_addr until memory answers with a
// one-cycle imem_ack.
interface pc_sequencer_if;
  import kgp_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack
  );

endinterface

// File: rtl/pc_sequencer_next_pc_select.sv
// Combinational branch resolution: picks the next PC from the sequential
// address, the branch label or the link register, and reports the raw
// low bits of whichever target was chosen so the caller can flag a
// misaligned branch.
module next_pc_select
  import kgp_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_STEP = PC_STEP_DEF
) (
  input  logic [3:0]      branch_op,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] label,
  input  logic [PC_W-1:0] ra,
  input  logic            carry,
  input  logic            zero,
  input  logic            sign,
  output logic [PC_W-1:0] next_pc,
  output logic [PC_W-1:0] seq_pc,
  output logic            link_we,
  output logic [1:0]      target_lo
);

  logic            use_tgt;
  logic [PC_W-1:0] tgt;

  // Decode the branch opcode into "take a target?" and which target
  always_comb begin
    use_tgt = 1'b0;
    tgt     = label;
    link_we = 1'b0;
    unique case (branch_op)
      BR_B:    use_tgt = 1'b1;
      BR_BL: begin
        use_tgt = 1'b1;
        link_we = 1'b1;
      end
      BR_BCY:  use_tgt = carry;
      BR_BNCY: use_tgt = ~carry;
      BR_BR: begin
        use_tgt = 1'b1;
        tgt     = ra;
      end
      BR_BLTZ: use_tgt = sign;
      BR_BZ:   use_tgt = zero;
      BR_BNZ:  use_tgt = ~zero;
      default: use_tgt = 1'b0;
    endcase
  end

  // Targets are word-aligned by dropping the low two bits; seq wraps mod 2^32
  always_comb begin
    seq_pc    = pc + PC_STEP;
    next_pc   = use_tgt ? {tgt[PC_W-1:2], 2'b00} : seq_pc;
    target_lo = use_tgt ? tgt[1:0] : 2'b00;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program-counter controller. Owns pc and ra, walks each
// instruction through fetch and execute, and retires it by loading the
// resolved next PC when the execute stage reports completion.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_BOOT   | first cycle out of reset, nothing issued yet
// ST_FETCH  | imem_req high at pc, waiting for imem_ack
// ST_EXEC   | instruction handed to decode, waiting for ex_done
// ST_HALTED | parked at an instruction boundary while halt is high
module pc_sequencer
  import kgp_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [PC_W-1:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.master  imem,
  output logic            instr_valid,
  input  logic            ex_done,
  input  logic [3:0]      branch_op,
  input  logic [PC_W-1:0] label,
  input  logic            carry,
  input  logic            zero,
  input  logic            sign,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] ra,
  output logic            taken,
  output logic            misalign,
  output logic            busy
);

  seq_state_t      state, state_nxt;
  logic            retire;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] seq_pc;
  logic            link_we;
  logic [1:0]      target_lo;

  next_pc_select #(
    .PC_STEP (PC_STEP)
  ) u_next_pc_select (
    .branch_op (branch_op),
    .pc        (pc),
    .label     (label),
    .ra        (ra),
    .carry     (carry),
    .zero      (zero),
    .sign      (sign),
    .next_pc   (next_pc),
    .seq_pc    (seq_pc),
    .link_we   (link_we),
    .target_lo (target_lo)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_BOOT;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; halt is only looked at on retire
  // or while parked, never in the middle of a fetch
  always_comb begin
    state_nxt   = state;
    imem.imem_req = 1'b0;
    instr_valid = 1'b0;
    retire      = 1'b0;
    unique case (state)
      ST_BOOT: state_nxt = ST_FETCH;
      ST_FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          instr_valid = 1'b1;
          state_nxt   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ex_done) begin
          retire    = 1'b1;
          state_nxt = halt ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: begin
        if (!halt) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  // pc only moves on retire, which keeps imem_addr steady through a fetch
  assign imem.imem_addr = pc;
  assign busy           = (state != ST_HALTED);

  // Architectural registers and retire-time status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      ra       <= '0;
      taken    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      taken <= 1'b0;
      if (retire) begin
        pc    <= next_pc;
        taken <= (next_pc != seq_pc);
        if (link_we)          ra       <= seq_pc;
        if (|target_lo)       misalign <= 1'b1;
      end
    end
  end

endmodule
